// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target block.
package spi_target_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] IDLE_FILL = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_target_if.sv
// SPI pins plus the local rx/tx handshake of the SPI target.
interface spi_target_if;
  import spi_target_pkg::*;

  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic              frame_active;
  logic              underrun;
  logic              underrun_clr;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_load, underrun_clr,
    output spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready,
           frame_active, underrun
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_load, underrun_clr,
    input  spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready,
           frame_active, underrun
  );

endinterface

// File: rtl/spi_target_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with rise/fall detect.
// SYNC_STAGES must be at least 2.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Next values: shift the raw pin in, keep a delayed copy of the output
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer chain and delayed copy, reset to the idle bus level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  =  level_o & ~prev_q;
  assign fall_o  = ~level_o &  prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: synchronized pins, byte rx/tx, one-entry tx buffer.
module spi_target #(
  parameter int unsigned        DATA_W      = spi_target_pkg::DATA_W,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  IDLE_FILL   = spi_target_pkg::IDLE_FILL
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_target_if.slave bus
);
  import spi_target_pkg::*;

  // Synchronized pin views
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_rise, cs_fall, cs_lvl;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  // FSM
  state_e state_q, state_d;

  // Post-reset arming: a chip select already low after reset is not a frame
  logic [SYNC_STAGES:0] flush_q, flush_d;
  logic                 armed_q, armed_d;

  // Datapath
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              load_pend_q, load_pend_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              underrun_q, underrun_d;
  logic              underrun_set;

  // FSM outputs
  logic active, miso_oe, start_load, in_frame, byte_load;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (bus.spi_sclk),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (bus.spi_cs_n),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (bus.spi_mosi),
    .level_o (mosi_lvl),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: frames open on an armed cs_n fall, close on a cs_n rise
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall && armed_q) state_d = ACTIVE;
      ACTIVE:  if (cs_rise)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: byte-load strobes and MISO enable
  always_comb begin
    active     = (state_q == ACTIVE);
    miso_oe    = active && !cs_lvl;
    start_load = (state_q == IDLE) && (state_d == ACTIVE);
    in_frame   = active && !cs_rise;
    byte_load  = start_load || (load_pend_q && in_frame);
  end

  // Arming: wait until the synchronizers hold real samples, then see cs_n high
  always_comb begin
    flush_d = {flush_q[SYNC_STAGES-1:0], 1'b1};
    armed_d = armed_q || (flush_q[SYNC_STAGES] && cs_lvl);
  end

  // Datapath next state: rx shift on sclk rise, tx shift on sclk fall,
  // byte load at each byte start, tx buffer write, sticky underrun
  always_comb begin
    cnt_d        = cnt_q;
    rx_sh_d      = rx_sh_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    load_pend_d  = 1'b0;
    tx_sh_d      = tx_sh_q;
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    underrun_set = 1'b0;

    if (active) begin
      if (cs_rise) begin
        // Partial byte is dropped; rx_data keeps its last complete value
        cnt_d   = '0;
        rx_sh_d = '0;
      end else begin
        if (sclk_rise) begin
          rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_lvl};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            rx_data_d   = rx_sh_d;
            rx_valid_d  = 1'b1;
            load_pend_d = 1'b1;
          end
        end
        // The fall right after the 8th rise precedes the new MSB, so no shift
        if (sclk_fall && (cnt_q != '0)) begin
          tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        end
      end
    end

    if (byte_load) begin
      if (buf_full_q) begin
        tx_sh_d    = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_sh_d      = IDLE_FILL;
        underrun_set = 1'b1;
      end
    end

    // Only an empty buffer accepts a write; a write coinciding with an
    // empty-buffer byte load is kept for the following byte
    if (bus.tx_load && !buf_full_q) begin
      buf_d      = bus.tx_data;
      buf_full_d = 1'b1;
    end

    underrun_d = underrun_q;
    if (bus.underrun_clr) underrun_d = 1'b0;
    if (underrun_set)     underrun_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_q     <= '0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      load_pend_q <= 1'b0;
      tx_sh_q     <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      load_pend_q <= load_pend_d;
      tx_sh_q     <= tx_sh_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.spi_miso     = miso_oe & tx_sh_q[DATA_W-1];
  assign bus.spi_miso_oe  = miso_oe;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.tx_ready     = ~buf_full_q;
  assign bus.frame_active = active;
  assign bus.underrun     = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: vector table plus corner sequences,
// with queue scoreboards for received bytes and MISO bytes.
module tb_spi_target;

  typedef struct {
    logic       preload;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic       exp_ur_start;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_target_if bus ();

  spi_target #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] rx_q[$];
  logic [7:0] miso_q[$];
  logic       rv_prev = 1'b0;
  vec_t       vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Received-byte scoreboard and rx_valid pulse width
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid === 1'b1) begin
      chk("rx_valid_single_cycle", {31'b0, rv_prev}, 32'd0);
      if (rx_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rx_unexpected: rx_valid with rx_data=%02h, required no rx_valid", bus.rx_data);
      end else begin
        chk("rx_data", {24'b0, bus.rx_data}, {24'b0, rx_q.pop_front()});
      end
    end
    rv_prev = bus.rx_valid;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic xfer(input logic [7:0] mo, input int nb, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      bus.spi_mosi = mo[i];
      repeat (4) @(negedge clk);
      mi[i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] mo, input logic [7:0] exp_miso, input string tag);
    logic [7:0] mi;
    rx_q.push_back(mo);
    miso_q.push_back(exp_miso);
    xfer(mo, 8, mi);
    if (miso_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: miso byte %02h with empty scoreboard, required an entry", tag, mi);
    end else begin
      chk(tag, {24'b0, mi}, {24'b0, miso_q.pop_front()});
    end
  endtask

  task automatic frame_start();
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (2) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic tx_preload(input logic [7:0] b);
    bus.tx_data = b;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    chk("preload_tx_ready", {31'b0, bus.tx_ready}, 32'd0);
  endtask

  task automatic clr_underrun();
    bus.underrun_clr = 1'b1;
    @(negedge clk);
    bus.underrun_clr = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_data"},      {24'b0, bus.rx_data},      32'd0);
    chk({tag, "_rx_valid"},     {31'b0, bus.rx_valid},     32'd0);
    chk({tag, "_tx_ready"},     {31'b0, bus.tx_ready},     32'd1);
    chk({tag, "_miso"},         {31'b0, bus.spi_miso},     32'd0);
    chk({tag, "_miso_oe"},      {31'b0, bus.spi_miso_oe},  32'd0);
    chk({tag, "_frame_active"}, {31'b0, bus.frame_active}, 32'd0);
    chk({tag, "_underrun"},     {31'b0, bus.underrun},     32'd0);
  endtask

  initial begin
    logic [7:0] dummy;

    vecs[0] = '{preload: 1'b1, tx: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_ur_start: 1'b0};
    vecs[1] = '{preload: 1'b0, tx: 8'h00, mosi: 8'hC3, exp_miso: 8'hFF, exp_ur_start: 1'b1};
    vecs[2] = '{preload: 1'b1, tx: 8'h00, mosi: 8'hFF, exp_miso: 8'h00, exp_ur_start: 1'b0};
    vecs[3] = '{preload: 1'b1, tx: 8'h81, mosi: 8'h00, exp_miso: 8'h81, exp_ur_start: 1'b0};

    bus.spi_sclk     = 1'b0;
    bus.spi_cs_n     = 1'b1;
    bus.spi_mosi     = 1'b0;
    bus.tx_data      = 8'h00;
    bus.tx_load      = 1'b0;
    bus.underrun_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs("reset");
    repeat (4) @(negedge clk);

    // Single-byte frames from the vector table
    for (int v = 0; v < 4; v++) begin
      clr_underrun();
      if (vecs[v].preload) tx_preload(vecs[v].tx);
      frame_start();
      chk($sformatf("vec%0d_underrun_at_start", v), {31'b0, bus.underrun}, {31'b0, vecs[v].exp_ur_start});
      chk($sformatf("vec%0d_tx_ready_at_start", v), {31'b0, bus.tx_ready}, 32'd1);
      chk($sformatf("vec%0d_frame_active", v), {31'b0, bus.frame_active}, 32'd1);
      send_byte(vecs[v].mosi, vecs[v].exp_miso, $sformatf("vec%0d_miso", v));
      frame_end();
      chk($sformatf("vec%0d_underrun_after_trailing_load", v), {31'b0, bus.underrun}, 32'd1);
      chk($sformatf("vec%0d_tx_ready_end", v), {31'b0, bus.tx_ready}, 32'd1);
      chk($sformatf("vec%0d_rx_data_end", v), {24'b0, bus.rx_data}, {24'b0, vecs[v].mosi});
    end

    // Two-byte frame: 56 from the buffer, then idle fill
    clr_underrun();
    tx_preload(8'h56);
    frame_start();
    chk("two_byte_underrun_start", {31'b0, bus.underrun}, 32'd0);
    send_byte(8'h12, 8'h56, "two_byte_miso0");
    send_byte(8'h34, 8'hFF, "two_byte_miso1");
    frame_end();
    chk("two_byte_underrun_end", {31'b0, bus.underrun}, 32'd1);
    chk("two_byte_tx_ready", {31'b0, bus.tx_ready}, 32'd1);

    // Frame aborted after 5 bits, then a full byte
    frame_start();
    xfer(8'hB7, 5, dummy);
    frame_end();
    chk("abort_rx_data_kept", {24'b0, bus.rx_data}, 32'h34);
    chk("abort_frame_closed", {31'b0, bus.frame_active}, 32'd0);
    frame_start();
    send_byte(8'h81, 8'hFF, "after_abort_miso");
    frame_end();
    chk("after_abort_rx_data", {24'b0, bus.rx_data}, 32'h81);

    // tx_load in the exact byte-load cycle with the buffer empty
    clr_underrun();
    chk("same_cycle_underrun_cleared", {31'b0, bus.underrun}, 32'd0);
    bus.spi_cs_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.tx_data = 8'hC3;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    chk("same_cycle_underrun_set", {31'b0, bus.underrun}, 32'd1);
    chk("same_cycle_tx_stored", {31'b0, bus.tx_ready}, 32'd0);
    @(negedge clk);
    send_byte(8'h5A, 8'hFF, "same_cycle_miso0");
    chk("same_cycle_buffer_consumed", {31'b0, bus.tx_ready}, 32'd1);
    send_byte(8'hA5, 8'hC3, "same_cycle_miso1");
    frame_end();
    chk("same_cycle_underrun_end", {31'b0, bus.underrun}, 32'd1);

    // underrun_clr coinciding with an underrun event: set wins
    bus.spi_cs_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.underrun_clr = 1'b1;
    @(negedge clk);
    bus.underrun_clr = 1'b0;
    chk("underrun_set_wins", {31'b0, bus.underrun}, 32'd1);
    @(negedge clk);
    send_byte(8'hE7, 8'hFF, "set_wins_miso");
    frame_end();
    clr_underrun();
    chk("underrun_clr_alone", {31'b0, bus.underrun}, 32'd0);

    // Reset pulse mid-byte with cs_n held low
    frame_start();
    xfer(8'hAA, 3, dummy);
    tx_preload(8'h99);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs("midreset");
    xfer(8'h55, 5, dummy);
    xfer(8'h3C, 8, dummy);
    chk("midreset_no_frame", {31'b0, bus.frame_active}, 32'd0);
    chk("midreset_miso_oe", {31'b0, bus.spi_miso_oe}, 32'd0);
    frame_end();
    chk("midreset_rx_data_still_reset", {24'b0, bus.rx_data}, 32'd0);
    frame_start();
    send_byte(8'h66, 8'hFF, "midreset_next_miso");
    frame_end();
    chk("midreset_next_rx_data", {24'b0, bus.rx_data}, 32'h66);

    // Scoreboards drained
    repeat (4) @(negedge clk);
    chk("rx_scoreboard_empty", rx_q.size(), 32'd0);
    chk("miso_scoreboard_empty", miso_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
